// File: rtl/adxl345_pkg.sv
// Shared ADXL345 SPI definitions: register map, bit indices, FSM states.
// Used by both the responder and the master side.
package adxl345_pkg;

  localparam logic [5:0] ADDR_DEVID       = 6'h00;
  localparam logic [5:0] ADDR_BW_RATE     = 6'h2C;
  localparam logic [5:0] ADDR_POWER_CTL   = 6'h2D;
  localparam logic [5:0] ADDR_INT_ENABLE  = 6'h2E;
  localparam logic [5:0] ADDR_INT_MAP     = 6'h2F;
  localparam logic [5:0] ADDR_INT_SOURCE  = 6'h30;
  localparam logic [5:0] ADDR_DATA_FORMAT = 6'h31;
  localparam logic [5:0] ADDR_DATAX0      = 6'h32;
  localparam logic [5:0] ADDR_DATAX1      = 6'h33;
  localparam logic [5:0] ADDR_DATAY0      = 6'h34;
  localparam logic [5:0] ADDR_DATAY1      = 6'h35;
  localparam logic [5:0] ADDR_DATAZ0      = 6'h36;
  localparam logic [5:0] ADDR_DATAZ1      = 6'h37;

  localparam int PWR_MEASURE    = 3;
  localparam int INT_DATA_READY = 7;
  localparam int FMT_INT_INVERT = 5;
  localparam int FMT_SPI        = 6;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    READ,
    WRITE
  } resp_state_t;

  function automatic logic [15:0] sext10(
    input logic [9:0] v
  );
    return {{6{v[9]}}, v};
  endfunction

endpackage

// File: rtl/adxl345_spi_sync_edge.sv
// Synchronizers for the SPI pads plus edge pulses on sclk and cs_n.
module adxl345_spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sclk_i,
  input  logic cs_n_i,
  input  logic sdio_i,
  output logic sclk_rise_o,
  output logic sclk_fall_o,
  output logic cs_fall_o,
  output logic cs_rise_o,
  output logic sdio_o
);

  logic [SYNC_STAGES-1:0] sclk_q;
  logic [SYNC_STAGES-1:0] cs_q;
  logic [SYNC_STAGES-1:0] sdio_q;
  logic                   sclk_prev_q;
  logic                   cs_prev_q;
  logic                   sclk_s;
  logic                   cs_s;

  assign sclk_s = sclk_q[SYNC_STAGES-1];
  assign cs_s   = cs_q[SYNC_STAGES-1];

  // Idle-high reset values keep CPOL=1 sclk and cs_n from faking an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_q      <= '1;
      cs_q        <= '1;
      sdio_q      <= '0;
      sclk_prev_q <= 1'b1;
      cs_prev_q   <= 1'b1;
    end else begin
      sclk_q      <= {sclk_q[SYNC_STAGES-2:0], sclk_i};
      cs_q        <= {cs_q[SYNC_STAGES-2:0], cs_n_i};
      sdio_q      <= {sdio_q[SYNC_STAGES-2:0], sdio_i};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
    end
  end

  assign sclk_rise_o = sclk_s & ~sclk_prev_q;
  assign sclk_fall_o = ~sclk_s & sclk_prev_q;
  assign cs_fall_o   = ~cs_s & cs_prev_q;
  assign cs_rise_o   = cs_s & ~cs_prev_q;
  assign sdio_o      = sdio_q[SYNC_STAGES-1];

endmodule

// File: rtl/adxl345_spi_responder.sv
// ADXL345 3-wire SPI slave model: register file, axis samples, INT1.
// ADXL345_RESP_4WIRE_EN adds 4-wire read-out on sdo (DATA_FORMAT[6]=0).
module adxl345_spi_responder
  import adxl345_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] DEVID_VAL   = 8'hE5,
  parameter logic [7:0] BW_RATE_RST = 8'h0A
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic       sdio_i,
  output logic       sdio_o,
  output logic       sdio_oe,
  output logic       sdo,
  output logic       int1,
  input  logic [9:0] x_in,
  input  logic [9:0] y_in,
  input  logic [9:0] z_in,
  input  logic       sample_valid
);

  resp_state_t     state_q, state_d;
  logic            sck_r, sck_f, cs_f, cs_r, sdi;
  logic [2:0]      bit_cnt_q;
  logic [6:0]      rx_q;
  logic [7:0]      rx_byte;
  logic            byte_done;
  logic            mb_q, done_q;
  logic [5:0]      addr_q;
  logic [7:0]      tx_q;
  logic [5:0][7:0] snap_q;
  logic [47:0]     live;
  logic [7:0]      bw_q, pwr_q, ie_q, map_q, fmt_q;
  logic [9:0]      x_q, y_q, z_q;
  logic            drdy_q, int1_q;
  logic            sdio_o_q, sdio_oe_q;
  logic [5:0]      rd_addr;
  logic [2:0]      rd_idx;
  logic [7:0]      rd_data;
  logic            wr_en, smp, drdy_clr, four_wire;

  adxl345_spi_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk        (clk),
    .rst        (rst),
    .sclk_i     (sclk),
    .cs_n_i     (cs_n),
    .sdio_i     (sdio_i),
    .sclk_rise_o(sck_r),
    .sclk_fall_o(sck_f),
    .cs_fall_o  (cs_f),
    .cs_rise_o  (cs_r),
    .sdio_o     (sdi)
  );

  assign rx_byte   = {rx_q, sdi};
  assign byte_done = sck_r & (bit_cnt_q == 3'd7);
  assign live      = {sext10(z_q), sext10(y_q), sext10(x_q)};
  assign wr_en     = (state_q == WRITE) & byte_done & ~done_q;
  assign smp       = sample_valid & pwr_q[PWR_MEASURE];
  assign drdy_clr  = (state_q == READ) & byte_done & ~done_q
                   & (addr_q == ADDR_DATAZ1);

`ifdef ADXL345_RESP_4WIRE_EN
  logic sdo_q;
  assign four_wire = ~fmt_q[FMT_SPI];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sdo_q <= 1'b0;
    else if (cs_r) sdo_q <= 1'b0;
    else if (state_q == READ && sck_f && four_wire) sdo_q <= tx_q[7];
  end
  assign sdo = sdo_q;
`else
  assign four_wire = 1'b0;
  assign sdo       = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:        if (cs_f) state_d = CMD;
      CMD:         if (byte_done) state_d = rx_byte[7] ? READ : WRITE;
      READ, WRITE: ;
    endcase
    if (cs_r) state_d = IDLE;
  end

  // Preload target: command address, or the next address of a burst.
  always_comb begin
    rd_addr = (state_q == CMD) ? rx_byte[5:0] : addr_q + 6'd1;
    rd_idx  = 3'(rd_addr - ADDR_DATAX0);
    rd_data = 8'h00;
    case (rd_addr)
      ADDR_DEVID:       rd_data = DEVID_VAL;
      ADDR_BW_RATE:     rd_data = bw_q;
      ADDR_POWER_CTL:   rd_data = pwr_q;
      ADDR_INT_ENABLE:  rd_data = ie_q;
      ADDR_INT_MAP:     rd_data = map_q;
      ADDR_INT_SOURCE:  rd_data = {drdy_q, 7'b0};
      ADDR_DATA_FORMAT: rd_data = fmt_q;
      ADDR_DATAX0, ADDR_DATAX1, ADDR_DATAY0,
      ADDR_DATAY1, ADDR_DATAZ0, ADDR_DATAZ1:
        rd_data = snap_q[rd_idx];
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt_q <= '0;
      rx_q      <= '0;
      mb_q      <= 1'b0;
      done_q    <= 1'b0;
      addr_q    <= '0;
      tx_q      <= '0;
      snap_q    <= '0;
      sdio_o_q  <= 1'b0;
      sdio_oe_q <= 1'b0;
    end else begin
      if (sck_r) begin
        rx_q      <= rx_byte[6:0];
        bit_cnt_q <= bit_cnt_q + 3'd1;
      end
      unique case (state_q)
        IDLE: if (cs_f) begin
          bit_cnt_q <= '0;
          snap_q    <= live;
        end
        CMD: if (byte_done) begin
          mb_q   <= rx_byte[6];
          addr_q <= rx_byte[5:0];
          tx_q   <= rd_data;
          done_q <= 1'b0;
        end
        READ: begin
          if (sck_f) begin
            tx_q <= {tx_q[6:0], 1'b0};
            if (!four_wire) begin
              sdio_oe_q <= 1'b1;
              sdio_o_q  <= tx_q[7];
            end
          end
          if (byte_done) begin
            tx_q <= mb_q ? rd_data : 8'h00;
            if (mb_q) addr_q <= addr_q + 6'd1;
            else      done_q <= 1'b1;
          end
        end
        WRITE: if (byte_done) begin
          if (mb_q) addr_q <= addr_q + 6'd1;
          else      done_q <= 1'b1;
        end
      endcase
      if (cs_r) begin
        sdio_oe_q <= 1'b0;
        sdio_o_q  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bw_q   <= BW_RATE_RST;
      pwr_q  <= '0;
      ie_q   <= '0;
      map_q  <= '0;
      fmt_q  <= '0;
      x_q    <= '0;
      y_q    <= '0;
      z_q    <= '0;
      drdy_q <= 1'b0;
      int1_q <= 1'b0;
    end else begin
      if (wr_en) begin
        case (addr_q)
          ADDR_BW_RATE:     bw_q  <= rx_byte;
          ADDR_POWER_CTL:   pwr_q <= rx_byte;
          ADDR_INT_ENABLE:  ie_q  <= rx_byte;
          ADDR_INT_MAP:     map_q <= rx_byte;
          ADDR_DATA_FORMAT: fmt_q <= rx_byte;
          default: ;
        endcase
      end
      // A new sample beats a same-cycle read-out clear.
      if (smp) begin
        x_q    <= x_in;
        y_q    <= y_in;
        z_q    <= z_in;
        drdy_q <= 1'b1;
      end else if (drdy_clr) begin
        drdy_q <= 1'b0;
      end
      int1_q <= (drdy_q & ie_q[INT_DATA_READY] & ~map_q[INT_DATA_READY])
              ^ fmt_q[FMT_INT_INVERT];
    end
  end

  assign sdio_o  = sdio_o_q;
  assign sdio_oe = sdio_oe_q;
  assign int1    = int1_q;

endmodule

// File: tb/tb_adxl345_spi_responder.sv
// Self-checking bench: SPI master driver plus register-level device model.
`timescale 1ns/1ps
module tb_adxl345_spi_responder;

  localparam int SS   = 2;
  localparam int HALF = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sclk = 1'b1;
  logic       cs_n = 1'b1;
  logic       sdio_i = 1'b0;
  logic       sample_valid = 1'b0;
  logic [9:0] x_in = '0;
  logic [9:0] y_in = '0;
  logic [9:0] z_in = '0;
  logic       sdio_o, sdio_oe, sdo, int1;

  int npass = 0;
  int ntot  = 0;

  logic [7:0] mreg  [0:63];
  logic [7:0] msnap [0:5];
  logic [9:0] mx, my, mz;
  logic       mdr;
  logic [7:0] wdat  [0:7];
  logic [7:0] rxb   [0:7];

  logic [5:0] alist [0:13] = '{6'h00, 6'h2C, 6'h2D, 6'h2E, 6'h2F,
    6'h30, 6'h31, 6'h32, 6'h33, 6'h34, 6'h35, 6'h36, 6'h37, 6'h3F};
  logic [5:0] wlist [0:6] = '{6'h2C, 6'h2D, 6'h2E, 6'h2F, 6'h31,
    6'h00, 6'h10};

  always #10 clk = ~clk;

  adxl345_spi_responder #(.SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n),
    .sdio_i(sdio_i), .sdio_o(sdio_o), .sdio_oe(sdio_oe),
    .sdo(sdo), .int1(int1), .x_in(x_in), .y_in(y_in),
    .z_in(z_in), .sample_valid(sample_valid)
  );

  task automatic check1(input string nm, input logic act, input logic exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %b expected %b", nm, act, exp);
  endtask

  task automatic check8(input string nm, input logic [7:0] act,
                        input logic [7:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %02h expected %02h", nm, act, exp);
  endtask

  function automatic bit is_rw(input int a);
    return a == 'h2C || a == 'h2D || a == 'h2E || a == 'h2F || a == 'h31;
  endfunction

  // Data byte i (0..5 = X0..Z1) of the live sample, as a 16-bit signed value.
  function automatic logic [7:0] live_byte(input int i);
    logic [9:0] s;
    int v;
    s = (i < 2) ? mx : (i < 4) ? my : mz;
    v = int'($signed(s));
    return (i % 2 == 0) ? v[7:0] : v[15:8];
  endfunction

  function automatic logic [7:0] mread(input int a);
    if (a == 0) return 8'hE5;
    if (a == 'h30) return mdr ? 8'h80 : 8'h00;
    if (a >= 'h32 && a <= 'h37) return msnap[a - 'h32];
    if (is_rw(a)) return mreg[a];
    return 8'h00;
  endfunction

  function automatic logic m_int();
    return (mdr & mreg['h2E][7] & ~mreg['h2F][7]) ^ mreg['h31][5];
  endfunction

  task automatic half_p;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic msample(input logic [9:0] x, input logic [9:0] y,
                         input logic [9:0] z);
    @(negedge clk);
    x_in = x; y_in = y; z_in = z;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    if (mreg['h2D][3]) begin
      mx = x; my = y; mz = z;
      mdr = 1'b1;
    end
  endtask

  // One sclk period: drive on fall, sample DUT just before the rise.
  task automatic sbit(input logic b, input logic exp_oe, output logic got);
    sclk = 1'b0;
    sdio_i = b;
    half_p;
    check1("sdio_oe", sdio_oe, exp_oe);
    got = sdio_o;
    sclk = 1'b1;
    half_p;
  endtask

  task automatic xfer(input logic [7:0] cmd, input int n, input bit midsamp);
    logic g;
    logic [7:0] rb;
    int a;
    bit rd, mb;
    rd = cmd[7];
    mb = cmd[6];
    a = {26'b0, cmd[5:0]};
    rb = '0;
    cs_n = 1'b0;
    for (int i = 0; i < 6; i++) msnap[i] = live_byte(i);
    half_p;
    if (midsamp) msample(10'($urandom), 10'($urandom), 10'($urandom));
    for (int i = 7; i >= 0; i--) sbit(cmd[i], 1'b0, g);
    for (int k = 0; k < n; k++) begin
      for (int i = 7; i >= 0; i--) begin
        sbit(wdat[k][i], rd, g);
        rb[i] = g;
        check1("sdo", sdo, 1'b0);
      end
      rxb[k] = rb;
      if (mb || k == 0) begin
        if (rd) begin
          check8("rd_byte", rb, mread(a));
          if (a == 'h37) mdr = 1'b0;
        end else if (is_rw(a)) begin
          mreg[a] = wdat[k];
        end
        if (mb) a = (a + 1) % 64;
      end else if (rd) begin
        check8("rd_pad", rb, 8'h00);
      end
    end
    cs_n = 1'b1;
    repeat (SS + 2) @(negedge clk);
    check1("oe_after_cs", sdio_oe, 1'b0);
    check1("int1", int1, m_int());
    half_p;
  endtask

  task automatic xfer_abort(input logic [7:0] cmd, input int nb);
    logic g;
    cs_n = 1'b0;
    half_p;
    for (int i = 7; i >= 0; i--) sbit(cmd[i], 1'b0, g);
    for (int i = 0; i < nb; i++) sbit(1'b1, 1'b0, g);
    cs_n = 1'b1;
    repeat (SS + 2) @(negedge clk);
    check1("oe_abort", sdio_oe, 1'b0);
    half_p;
  endtask

  task automatic wr1(input logic [5:0] a, input logic [7:0] d);
    wdat[0] = d;
    xfer({2'b00, a}, 1, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 64; i++) mreg[i] = 8'h00;
    mreg['h2C] = 8'h0A;
    mx = '0; my = '0; mz = '0; mdr = 1'b0;
    for (int i = 0; i < 8; i++) wdat[i] = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check1("rst_sdio_o", sdio_o, 1'b0);
    check1("rst_sdio_oe", sdio_oe, 1'b0);
    check1("rst_sdo", sdo, 1'b0);
    check1("rst_int1", int1, 1'b0);

    xfer(8'hAC, 1, 1'b0);
    check8("rst_bw_rate", rxb[0], 8'h0A);
    xfer(8'h80, 1, 1'b0);
    check8("devid", rxb[0], 8'hE5);

    wr1(6'h2D, 8'h08);
    xfer(8'hAD, 1, 1'b0);
    check8("power_ctl", rxb[0], 8'h08);
    wr1(6'h00, 8'h12);
    xfer(8'h80, 1, 1'b0);
    check8("devid_ro", rxb[0], 8'hE5);

    msample(10'h3FF, 10'h1FF, 10'h200);
    xfer(8'hF2, 6, 1'b0);
    check8("sx_x0", rxb[0], 8'hFF);
    check8("sx_x1", rxb[1], 8'hFF);
    check8("sx_y0", rxb[2], 8'hFF);
    check8("sx_y1", rxb[3], 8'h01);
    check8("sx_z0", rxb[4], 8'h00);
    check8("sx_z1", rxb[5], 8'hFE);

    wr1(6'h2E, 8'h80);
    check1("int_idle", int1, 1'b0);
    msample(10'h001, 10'h002, 10'h003);
    @(negedge clk);
    check1("int_set", int1, 1'b1);
    xfer(8'hF2, 6, 1'b0);
    check1("int_clr", int1, 1'b0);
    wr1(6'h31, 8'h20);
    check1("inv_idle", int1, 1'b1);
    msample(10'h004, 10'h005, 10'h006);
    @(negedge clk);
    check1("inv_set", int1, 1'b0);
    xfer(8'hF2, 6, 1'b0);
    check1("inv_clr", int1, 1'b1);
    wr1(6'h31, 8'h00);

    xfer_abort(8'h2E, 3);
    xfer(8'hAE, 1, 1'b0);
    check8("abort_ie", rxb[0], 8'h80);

    xfer(8'hFF, 2, 1'b0);
    check8("wrap_3f", rxb[0], 8'h00);
    check8("wrap_00", rxb[1], 8'hE5);

    wr1(6'h2D, 8'h00);
    msample(10'h111, 10'h222, 10'h333);
    xfer(8'hB0, 1, 1'b0);
    check8("gate_src", rxb[0], 8'h00);
    xfer(8'hB2, 1, 1'b0);
    check8("gate_x0", rxb[0], 8'h04);

    wr1(6'h2D, 8'h08);
    for (int t = 0; t < 40; t++) begin
      int c, n;
      logic mb;
      logic [5:0] a;
      c = $urandom_range(0, 9);
      mb = 1'($urandom);
      n = $urandom_range(1, 4);
      for (int i = 0; i < 8; i++) wdat[i] = 8'($urandom);
      if (c < 3) begin
        a = wlist[$urandom_range(0, 6)];
        if (a == 6'h2D) wdat[0][3] = 1'($urandom_range(0, 3) != 0);
        xfer({1'b0, mb, a}, n, 1'b0);
      end else if (c < 5) begin
        msample(10'($urandom), 10'($urandom), 10'($urandom));
        repeat (2) @(negedge clk);
        check1("int1_smp", int1, m_int());
      end else begin
        a = (c == 9) ? 6'($urandom) : alist[$urandom_range(0, 13)];
        xfer({1'b1, mb, a}, n, $urandom_range(0, 3) == 0);
      end
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
